// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg : shared select codes, sequencer states and operand width   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package calc_pkg;

  localparam int OPERAND_W = 8;
  localparam int SEL_W     = 3;

  localparam logic [SEL_W-1:0] SEL_IDLE   = 3'b000;
  localparam logic [SEL_W-1:0] SEL_LOAD_A = 3'b001;
  localparam logic [SEL_W-1:0] SEL_LOAD_B = 3'b010;
  localparam logic [SEL_W-1:0] SEL_EXEC   = 3'b011;
  localparam logic [SEL_W-1:0] SEL_CLEAR  = 3'b100;

  typedef enum logic [2:0] {
    ST_CLR    = 3'd0,
    ST_WAIT_A = 3'd1,
    ST_LD_A   = 3'd2,
    ST_WAIT_B = 3'd3,
    ST_LD_B   = 3'd4,
    ST_WAIT_X = 3'd5,
    ST_EXEC   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // Where each timed hold state lands once its hold expires.
  function automatic state_t hold_exit(input state_t s);
    case (s)
      ST_CLR:  return ST_WAIT_A;
      ST_LD_A: return ST_WAIT_B;
      ST_LD_B: return ST_WAIT_X;
      default: return ST_DONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce : 2-flop synchroniser, counting debouncer, press pulse  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_press <= w_accept && !r_level;
      // Any sample agreeing with the accepted level restarts the run.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/calc_input_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_input_sequencer : button-driven operand/select sequencer         |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [OPERAND_W-1:0] sw,
  input  logic [1:0]           op_sw,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] data,
  output logic [SEL_W-1:0]     sel,
  output logic [1:0]           op_code,
  output logic                 busy
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  logic                 w_enter_level;
  logic                 w_enter_press;
  logic                 w_clear_level;
  logic                 w_clear_press;
  logic                 w_unused;
  logic                 w_hold_done;

  logic                 r_init;
  state_t               r_state;
  logic [HOLD_W-1:0]    r_hold;
  logic [OPERAND_W-1:0] r_data;
  logic [SEL_W-1:0]     r_sel;
  logic [1:0]           r_op;
  logic                 r_busy;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_enter),
    .level   (w_enter_level),
    .press   (w_enter_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_clear),
    .level   (w_clear_level),
    .press   (w_clear_press)
  );

  assign w_unused    = w_enter_level ^ w_clear_level;
  assign w_hold_done = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

  // r_init stays low through reset so the first live edge enters CLR.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init  <= 1'b0;
      r_state <= ST_CLR;
      r_hold  <= '0;
      r_data  <= '0;
      r_sel   <= SEL_IDLE;
      r_op    <= '0;
      r_busy  <= 1'b0;
    end else if (!r_init || (w_clear_press && r_state != ST_CLR)) begin
      r_init  <= 1'b1;
      r_state <= ST_CLR;
      r_hold  <= '0;
      r_data  <= '0;
      r_sel   <= SEL_CLEAR;
      r_busy  <= 1'b1;
    end else if (w_clear_press) begin
      r_hold <= '0;
    end else begin
      case (r_state)
        ST_CLR, ST_LD_A, ST_LD_B, ST_EXEC: begin
          if (w_hold_done) begin
            r_state <= hold_exit(r_state);
            r_hold  <= '0;
            r_sel   <= SEL_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_WAIT_A: if (w_enter_press) begin
          r_state <= ST_LD_A;
          r_data  <= sw;
          r_sel   <= SEL_LOAD_A;
          r_busy  <= 1'b1;
        end
        ST_WAIT_B: if (w_enter_press) begin
          r_state <= ST_LD_B;
          r_data  <= sw;
          r_sel   <= SEL_LOAD_B;
          r_busy  <= 1'b1;
        end
        ST_WAIT_X: if (w_enter_press) begin
          r_state <= ST_EXEC;
          r_op    <= op_sw;
          r_sel   <= SEL_EXEC;
          r_busy  <= 1'b1;
        end
        default: if (w_enter_press) begin
          r_state <= ST_CLR;
          r_data  <= '0;
          r_sel   <= SEL_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign data    = r_data;
  assign sel     = r_sel;
  assign op_code = r_op;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_calc_input_sequencer : directed self-checking bench               |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
module tb_calc_input_sequencer;

  localparam int DB   = 4;
  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [1:0] op_sw = 2'b00;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] data;
  logic [2:0] sel;
  logic [1:0] op_code;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_lda_cyc = 0;
  int n_ldb_cyc = 0;
  int n_enter_press = 0;
  int snap;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sw        (sw),
    .op_sw     (op_sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .data      (data),
    .sel       (sel),
    .op_code   (op_code),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (sel == 3'b001) n_lda_cyc++;
    if (sel == 3'b010) n_ldb_cyc++;
  end

  always @(posedge clock) if (u_dut.w_enter_press === 1'b1) n_enter_press++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] esel, input logic [7:0] edata,
                         input logic [1:0] eop);
    chk({tag, "_sel"},  {5'b0, sel},     {5'b0, esel});
    chk({tag, "_data"}, data,            edata);
    chk({tag, "_op"},   {6'b0, op_code}, {6'b0, eop});
    chk({tag, "_busy"}, {7'b0, busy},    {7'b0, (esel != 3'b000)});
  endtask

  // Clean Enter press from a WAIT/DONE state; press lands 2+DB cycles after the edge.
  task automatic do_enter(input string tag, input logic [2:0] esel, input logic [7:0] edata,
                          input logic [1:0] eop, input logic [7:0] pdata, input logic [1:0] pop);
    btn_enter = 1'b1;
    repeat (2 + DB - 1) @(negedge clock);
    chk({tag, "_nopress"}, {7'b0, u_dut.w_enter_press}, 8'h00);
    @(negedge clock);
    chk({tag, "_press"}, {7'b0, u_dut.w_enter_press}, 8'h01);
    chk_all({tag, "_pre"}, 3'b000, pdata, pop);
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clock);
      chk_all(tag, esel, edata, eop);
    end
    @(negedge clock);
    chk_all({tag, "_end"}, 3'b000, edata, eop);
    btn_enter = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    // Reset and the first CLR sequence.
    repeat (3) @(negedge clock);
    chk_all("rst", 3'b000, 8'h00, 2'b00);
    reset_n = 1'b1;
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clock);
      chk_all("clr0", 3'b100, 8'h00, 2'b00);
    end
    @(negedge clock);
    chk_all("wait_a0", 3'b000, 8'h00, 2'b00);

    // Full entry: A, B, operation, then Enter in DONE returns to CLR.
    sw = 8'h2A;
    do_enter("lda", 3'b001, 8'h2A, 2'b00, 8'h00, 2'b00);
    sw = 8'h15;
    do_enter("ldb", 3'b010, 8'h15, 2'b00, 8'h2A, 2'b00);
    op_sw = 2'b10;
    do_enter("exec", 3'b011, 8'h15, 2'b10, 8'h15, 2'b00);
    do_enter("done_clr", 3'b100, 8'h00, 2'b10, 8'h15, 2'b10);

    // Bouncy Enter: ten toggles every 2 cycles, then a final rise held high.
    sw = 8'h5C;
    snap = n_enter_press;
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      repeat (2) @(negedge clock);
    end
    btn_enter = 1'b1;
    repeat (2 + DB - 1) @(negedge clock);
    chk("bounce_nopress", 8'(n_enter_press - snap), 8'd0);
    chk("bounce_idle", {5'b0, sel}, 8'h00);
    @(negedge clock);
    chk("bounce_press", {7'b0, u_dut.w_enter_press}, 8'h01);
    snap = n_lda_cyc;
    @(negedge clock);
    chk_all("bounce_lda", 3'b001, 8'h5C, 2'b10);
    repeat (12) @(negedge clock);
    chk("bounce_one_press", 8'(n_enter_press), 8'(snap - snap + 5));
    chk("bounce_lda_cycles", 8'(n_lda_cyc - snap), 8'(HOLD));
    chk_all("bounce_wait_b", 3'b000, 8'h5C, 2'b10);
    btn_enter = 1'b0;
    repeat (8) @(negedge clock);

    // Clear arrives in hold cycle 2 of LD_B.
    sw = 8'h33;
    snap = n_ldb_cyc;
    btn_enter = 1'b1;
    repeat (2) @(negedge clock);
    btn_clear = 1'b1;
    repeat (5) @(negedge clock);
    chk_all("ldb_h1", 3'b010, 8'h33, 2'b10);
    @(negedge clock);
    chk_all("ldb_h2", 3'b010, 8'h33, 2'b10);
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clock);
      chk_all("abort_clr", 3'b100, 8'h00, 2'b10);
    end
    @(negedge clock);
    chk_all("abort_wait_a", 3'b000, 8'h00, 2'b10);
    chk("abort_ldb_cycles", 8'(n_ldb_cyc - snap), 8'd2);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (8) @(negedge clock);
    sw = 8'h44;
    do_enter("after_abort_lda", 3'b001, 8'h44, 2'b10, 8'h00, 2'b10);

    // Enter and Clear pulses together in WAIT_B: Clear wins.
    sw = 8'h99;
    snap = n_ldb_cyc;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    repeat (2 + DB) @(negedge clock);
    chk_all("both_pre", 3'b000, 8'h44, 2'b10);
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clock);
      chk_all("both_clr", 3'b100, 8'h00, 2'b10);
    end
    @(negedge clock);
    chk_all("both_wait_a", 3'b000, 8'h00, 2'b10);
    chk("both_no_ldb", 8'(n_ldb_cyc - snap), 8'd0);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (8) @(negedge clock);

    // Asynchronous reset in the middle of EXEC.
    sw = 8'h81;
    do_enter("r_lda", 3'b001, 8'h81, 2'b10, 8'h00, 2'b10);
    sw = 8'h7E;
    do_enter("r_ldb", 3'b010, 8'h7E, 2'b10, 8'h81, 2'b10);
    op_sw = 2'b01;
    btn_enter = 1'b1;
    repeat (2 + DB + 1) @(negedge clock);
    chk_all("r_exec", 3'b011, 8'h7E, 2'b01);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk_all("async_rst", 3'b000, 8'h00, 2'b00);
    btn_enter = 1'b0;
    repeat (3) @(negedge clock);
    chk_all("rst_held", 3'b000, 8'h00, 2'b00);
    reset_n = 1'b1;
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clock);
      chk_all("rst_clr", 3'b100, 8'h00, 2'b00);
    end
    @(negedge clock);
    chk_all("rst_wait_a", 3'b000, 8'h00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
